// File: rtl/coffee_order_ctrl.sv
// coffee_order_ctrl: customer-side order controller that collects credit, launches a brew and returns change.
module coffee_order_ctrl #(
    parameter int PRICE0      = 3,
    parameter int PRICE1      = 4,
    parameter int PRICE2      = 5,
    parameter int PRICE3      = 6,
    parameter int MAX_CREDIT  = 20,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [2:0] coin_value,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       brew_done,
    output logic       brew_start,
    output logic [1:0] brew_sel,
    output logic [7:0] credit,
    output logic       change_valid,
    output logic [7:0] change_amt,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       fault,
    output logic [2:0] ctrl_state
);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COLLECT   = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        REFUND    = 3'd4,
        FAULT     = 3'd5
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          done_prev;
    logic [8:0]    sum;
    logic [7:0]    price;
    logic          take_coin;

    assign sum   = {1'b0, credit} + {6'd0, coin_value};
    assign price = sel == 2'd0 ? 8'(PRICE0) :
                   sel == 2'd1 ? 8'(PRICE1) :
                   sel == 2'd2 ? 8'(PRICE2) : 8'(PRICE3);
    // A coin is consumed only when no higher-priority event claims the cycle.
    assign take_coin = (state == IDLE || state == COLLECT) && coin_valid && !cancel && !sel_valid &&
                       coin_value != 3'd0 && sum <= 9'(MAX_CREDIT);
    assign ctrl_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= 8'd0;
            brew_sel     <= 2'd0;
            cnt          <= '0;
            done_prev    <= 1'b0;
            brew_start   <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= 8'd0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            fault        <= 1'b0;
        end else begin
            brew_start   <= 1'b0;
            change_valid <= 1'b0;
            insufficient <= 1'b0;
            coin_reject  <= coin_valid && !take_coin;
            case (state)
                IDLE: begin
                    if (!cancel && sel_valid) insufficient <= 1'b1;
                    else if (take_coin) begin
                        credit <= sum[7:0];
                        state  <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (cancel) state <= REFUND;
                    else if (sel_valid) begin
                        if (credit >= price) begin
                            brew_sel <= sel;
                            credit   <= credit - price;
                            state    <= LAUNCH;
                        end else insufficient <= 1'b1;
                    end else if (take_coin) credit <= sum[7:0];
                end
                LAUNCH: begin
                    brew_start <= 1'b1;
                    cnt        <= '0;
                    done_prev  <= brew_done;
                    state      <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    done_prev <= brew_done;
                    // Only a fresh rising edge counts, so a level left over from the last brew is ignored.
                    if (brew_done && !done_prev) state <= REFUND;
                    else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end
                end
                REFUND: begin
                    if (credit != 8'd0) begin
                        change_valid <= 1'b1;
                        change_amt   <= credit;
                    end
                    credit <= 8'd0;
                    state  <= IDLE;
                end
                FAULT: fault <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coffee_order_ctrl.sv
// tb_coffee_order_ctrl: scoreboard bench; expected pulses are queued at stimulus time and matched as they appear.
module tb_coffee_order_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin_valid = 1'b0;
    logic [2:0] coin_value = 3'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       cancel = 1'b0;
    logic       brew_done = 1'b0;
    logic       brew_start;
    logic [1:0] brew_sel;
    logic [7:0] credit;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_reject;
    logic       insufficient;
    logic       fault;
    logic [2:0] ctrl_state;

    int checks = 0;
    int failures = 0;
    logic [15:0] sb[$];

    localparam int K_START = 0, K_CHANGE = 1, K_REJECT = 2, K_INSUFF = 3;

    coffee_order_ctrl dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel), .brew_done(brew_done),
        .brew_start(brew_start), .brew_sel(brew_sel), .credit(credit),
        .change_valid(change_valid), .change_amt(change_amt), .coin_reject(coin_reject),
        .insufficient(insufficient), .fault(fault), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ev(input int k, input int v);
        return {k[7:0], v[7:0]};
    endfunction

    task automatic pop_check(input string tag, input logic [15:0] got);
        if (sb.size() == 0) check({tag, "_unexpected"}, int'(got), -1);
        else check(tag, int'(got), int'(sb.pop_front()));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (brew_start) pop_check("start", ev(K_START, int'(brew_sel)));
            if (change_valid) pop_check("change", ev(K_CHANGE, int'(change_amt)));
            if (coin_reject) pop_check("reject", ev(K_REJECT, 0));
            if (insufficient) pop_check("insuff", ev(K_INSUFF, 0));
        end
    end

    task automatic step(input logic cv, input logic [2:0] cval, input logic sv, input logic [1:0] s, input logic c);
        coin_valid = cv; coin_value = cval; sel_valid = sv; sel = s; cancel = c;
        @(posedge clk); #1;
        coin_valid = 1'b0; coin_value = 3'd0; sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic coin(input logic [2:0] v);
        step(1'b1, v, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic pick(input logic [1:0] s);
        step(1'b0, 3'd0, 1'b1, s, 1'b0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_state", int'(ctrl_state), 0);
        check("rst_credit", int'(credit), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_start", int'(brew_start), 0);

        // exact-price order, no change
        coin(3'd2);
        check("t1_credit2", int'(credit), 2);
        check("t1_state", int'(ctrl_state), 1);
        coin(3'd1);
        check("t1_credit3", int'(credit), 3);
        sb.push_back(ev(K_START, 0));
        pick(2'd0);
        check("t1_launch", int'(ctrl_state), 2);
        check("t1_credit0", int'(credit), 0);
        check("t1_start_lat", int'(brew_start), 0);
        tick(1);
        check("t1_start", int'(brew_start), 1);
        check("t1_wait", int'(ctrl_state), 3);
        check("t1_bsel", int'(brew_sel), 0);
        tick(2);
        check("t1_start_once", int'(brew_start), 0);
        brew_done = 1'b1;
        tick(1);
        check("t1_refund", int'(ctrl_state), 4);
        tick(1);
        check("t1_idle", int'(ctrl_state), 0);
        brew_done = 1'b0;

        // order with change
        coin(3'd7);
        sb.push_back(ev(K_START, 2));
        pick(2'd2);
        check("t2_credit", int'(credit), 2);
        tick(1);
        check("t2_bsel", int'(brew_sel), 2);
        brew_done = 1'b1;
        tick(1);
        sb.push_back(ev(K_CHANGE, 2));
        tick(1);
        check("t2_change_amt", int'(change_amt), 2);
        check("t2_credit0", int'(credit), 0);
        brew_done = 1'b0;

        // insufficient then cancel
        coin(3'd3);
        sb.push_back(ev(K_INSUFF, 0));
        pick(2'd3);
        check("t3_state", int'(ctrl_state), 1);
        check("t3_credit", int'(credit), 3);
        step(1'b0, 3'd0, 1'b0, 2'd0, 1'b1);
        check("t3_refund", int'(ctrl_state), 4);
        sb.push_back(ev(K_CHANGE, 3));
        tick(1);
        check("t3_idle", int'(ctrl_state), 0);

        // coin rejection cases and credit ceiling
        coin(3'd7);
        coin(3'd7);
        sb.push_back(ev(K_REJECT, 0));
        coin(3'd7);
        check("t4_credit14", int'(credit), 14);
        coin(3'd6);
        check("t4_credit20", int'(credit), 20);
        sb.push_back(ev(K_REJECT, 0));
        coin(3'd1);
        check("t4_over_max", int'(credit), 20);
        sb.push_back(ev(K_REJECT, 0));
        coin(3'd0);
        check("t4_zero_coin", int'(credit), 20);
        sb.push_back(ev(K_REJECT, 0));
        sb.push_back(ev(K_START, 0));
        step(1'b1, 3'd1, 1'b1, 2'd0, 1'b0);
        check("t4_sel_wins", int'(credit), 17);
        check("t4_launch", int'(ctrl_state), 2);
        tick(1);
        sb.push_back(ev(K_REJECT, 0));
        coin(3'd1);
        check("t4_wait_coin", int'(credit), 17);
        check("t4_wait", int'(ctrl_state), 3);
        brew_done = 1'b1;
        tick(1);
        sb.push_back(ev(K_CHANGE, 17));
        tick(1);
        brew_done = 1'b0;

        // stale done level is ignored
        coin(3'd3);
        sb.push_back(ev(K_START, 0));
        pick(2'd0);
        brew_done = 1'b1;
        tick(3);
        check("t5_stale", int'(ctrl_state), 3);
        brew_done = 1'b0;
        tick(1);
        check("t5_low", int'(ctrl_state), 3);
        brew_done = 1'b1;
        tick(1);
        check("t5_rise", int'(ctrl_state), 4);
        tick(1);
        brew_done = 1'b0;
        check("t5_idle", int'(ctrl_state), 0);

        // timeout into sticky fault
        coin(3'd4);
        sb.push_back(ev(K_START, 0));
        pick(2'd0);
        tick(1);
        tick(999);
        check("t5_pre_timeout", int'(ctrl_state), 3);
        check("t5_pre_fault", int'(fault), 0);
        tick(1);
        check("t5_fault_state", int'(ctrl_state), 5);
        check("t5_fault", int'(fault), 1);
        sb.push_back(ev(K_REJECT, 0));
        coin(3'd2);
        check("t5_fault_credit", int'(credit), 1);
        brew_done = 1'b1;
        tick(5);
        brew_done = 1'b0;
        check("t5_sticky_state", int'(ctrl_state), 5);
        check("t5_sticky_fault", int'(fault), 1);
        do_reset();
        check("t5_cleared", int'(fault), 0);

        // asynchronous reset in WAIT_DONE
        coin(3'd7);
        sb.push_back(ev(K_START, 0));
        pick(2'd0);
        tick(2);
        check("t6_credit", int'(credit), 4);
        check("t6_wait", int'(ctrl_state), 3);
        #3 reset = 1'b1;
        #1;
        check("t6_state", int'(ctrl_state), 0);
        check("t6_credit0", int'(credit), 0);
        check("t6_bsel", int'(brew_sel), 0);
        check("t6_change", int'(change_valid), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick(4);
        check("t6_idle", int'(ctrl_state), 0);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coffee_order_ctrl.md
Name: coffee_order_ctrl

Overview:
Front-panel order controller that drives the coffee brewer FSM's start/coffee_sel/done interface from the customer side. It accumulates coin credit, validates a drink selection against its price, and issues a one-cycle start pulse with a held selection. It then waits for the brewer's done, returns leftover credit as change, and flags a fault if the brewer never finishes.

Parameters:
PRICE0, 3, price of selection 2'b00 (expreso), in coin units
PRICE1, 4, price of selection 2'b01, in coin units
PRICE2, 5, price of selection 2'b10, in coin units
PRICE3, 6, price of selection 2'b11, in coin units
MAX_CREDIT, 20, credit ceiling in coin units; must be <= 255
TIMEOUT_CYC, 1000, number of WAIT_DONE cycles without a done rising edge before a fault is raised

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
coin_valid  in  1  coin inserted this cycle
coin_value  in  3  coin worth in units; a value of 0 is invalid
sel_valid  in  1  selection button pressed this cycle
sel  in  2  drink selected
cancel  in  1  customer cancel request
brew_done  in  1  brewer done (level)
brew_start  out  1  one-cycle start pulse to the brewer
brew_sel  out  2  selection to the brewer; held from LAUNCH through WAIT_DONE
credit  out  8  current credit
change_valid  out  1  one-cycle pulse; change_amt is valid while it is high
change_amt  out  8  change returned
coin_reject  out  1  one-cycle pulse: coin not accepted
insufficient  out  1  one-cycle pulse: selection refused because credit < price
fault  out  1  sticky brewer-timeout flag
ctrl_state  out  3  IDLE=0, COLLECT=1, LAUNCH=2, WAIT_DONE=3, REFUND=4, FAULT=5

Behaviour:
- Outputs: all are registered.
- Reset values (asynchronous): ctrl_state=IDLE; credit=0; brew_sel=0; timeout counter=0; done_prev=0. All pulses and fault are 0. Asserting reset mid-order discards credit and produces no change pulse.
- Event priority in IDLE/COLLECT, one event per cycle: cancel > sel_valid > coin_valid. A coin that is not consumed in a cycle produces a coin_reject pulse on the next cycle.
- Coin acceptance: a coin is accepted only if coin_value != 0 and credit + coin_value <= MAX_CREDIT; otherwise the whole coin is rejected and credit is unchanged. A 9-bit sum is used for the comparison.
- IDLE:
  - Accepted coin: add it to credit, go to COLLECT.
  - sel_valid: insufficient pulse.
  - cancel: no effect.
- COLLECT:
  - cancel: go to REFUND.
  - sel_valid with credit >= PRICE[sel]: latch brew_sel=sel, credit -= price, go to LAUNCH.
  - sel_valid with credit < PRICE[sel]: insufficient pulse, stay in COLLECT.
  - Accepted coin: add it to credit.
- LAUNCH (exactly 1 cycle): brew_start=1. Clear the timeout counter. Next state is WAIT_DONE.
- Latency: a selection sampled at edge N gives brew_start high between edges N+1 and N+2.
- WAIT_DONE:
  - Register done_prev each cycle.
  - Completion is defined as brew_done=1 && done_prev=0, so a stale done level left from a previous brew is ignored. done_prev is loaded with brew_done during LAUNCH.
  - On completion, go to REFUND.
  - Otherwise increment the counter. When counter == TIMEOUT_CYC-1 and there is no completion, go to FAULT.
  - Coins are rejected; sel_valid and cancel are ignored.
- REFUND (1 cycle):
  - If credit > 0: change_valid=1, change_amt=credit.
  - If credit == 0: no pulse.
  - Either way, credit becomes 0 and the next state is IDLE.
  - Coins arriving in this cycle are rejected.
- FAULT: fault=1 until reset. Coins are rejected and credit is retained. brew_start stays 0.
- ctrl_state encodings 6 and 7 are illegal; they must recover to IDLE on the next edge.

Test Plan:
1. Coin 2, coin 1, then sel=00 -> credit 3 then 0; brew_start is high for exactly 1 cycle, one cycle after the sel edge; brew_sel=00. A brew_done rising edge then gives REFUND with no change_valid, followed by IDLE.
2. Coin 7, then sel=10 -> credit becomes 2 and the order launches. After the done rising edge: change_valid pulse with change_amt=2, then credit=0.
3. Coin 3, then sel=11 -> insufficient pulse and state stays COLLECT with credit 3. Then cancel -> change_valid pulse with change_amt=3, and no brew_start at any point.
4. Coins 7, 7, 7 -> credit 14 and coin_reject on the third coin. Coin_value=0 -> rejected. Coin plus sel in the same cycle -> sel is taken and the coin is rejected. A coin during WAIT_DONE -> rejected.
5. Hold brew_done=1 through LAUNCH -> no completion. Drop it and raise it again -> REFUND. Separately, never assert done -> after TIMEOUT_CYC cycles, fault=1 and ctrl_state=5, and both are sticky until reset.
6. Assert reset asynchronously in WAIT_DONE with credit 4 -> all outputs return to their reset values before the next clock edge. No change_valid pulse is ever produced.
